// File: rtl/time_board_mux_pkg.sv
// Shared constants and FSM encoding for the time board display mux.
package time_board_pkg;

    localparam logic MODE_DOWN = 1'b0;
    localparam logic MODE_UP   = 1'b1;

    localparam int TIME_W_DEF = 39;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INSERT = 2'd1,
        DROP   = 2'd2
    } state_t;

endpackage

// File: rtl/time_board_mux_if.sv
// Result-offer port: valid/ready handshake carrying mode and time, plus drop pulse.
interface time_board_mux_if #(
    parameter int TIME_W = 39
) ();

    logic              rec_valid;
    logic              rec_ready;
    logic              rec_mode;
    logic [TIME_W-1:0] rec_time;
    logic              rec_drop;

    modport master (
        output rec_valid,
        output rec_mode,
        output rec_time,
        input  rec_ready,
        input  rec_drop
    );

    modport slave (
        input  rec_valid,
        input  rec_mode,
        input  rec_time,
        output rec_ready,
        output rec_drop
    );

endinterface

// File: rtl/time_board_mux_rank_table.sv
// One ranked leaderboard. A new result is placed by walking an index from the
// bottom of the occupied region upward, one comparison per cycle, shifting
// worse entries down by one slot as it goes. When the table is full, a first
// check cycle compares against the last entry and rejects results that do not rank.
module rank_table #(
    parameter int TIME_W = 39,
    parameter int DEPTH  = 3,
    parameter bit ASCEND = 1'b1,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          load,
    input  logic                          step,
    input  logic [TIME_W-1:0]             new_time,
    output logic [DEPTH-1:0][TIME_W-1:0]  entries,
    output logic [CNT_W-1:0]              cnt,
    output logic                          rej,
    output logic                          done
);

    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  prev_idx;
    logic              chk;
    logic              full;
    logic              has_prev;
    logic              better;
    logic              shift;
    logic [TIME_W-1:0] cmp_entry;

    assign full = (cnt == CNT_W'(DEPTH));

    // Single comparator: against the last entry in the check cycle, else against entry[idx-1].
    always_comb begin
        prev_idx  = (idx == '0) ? '0 : idx - 1'b1;
        cmp_entry = chk ? entries[DEPTH-1] : entries[prev_idx];
        better    = ASCEND ? (new_time < cmp_entry) : (new_time > cmp_entry);
        has_prev  = (idx != '0);
        rej       = step && chk && !better;
        shift     = step && !chk && has_prev && better;
        done      = step && !chk && !(has_prev && better);
    end

    // Control: occupancy count, walking index and full-table check flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
            chk <= 1'b0;
        end else if (clear) begin
            cnt <= '0;
            chk <= 1'b0;
        end else if (load) begin
            idx <= full ? IDX_W'(DEPTH - 1) : IDX_W'(cnt);
            chk <= full;
        end else if (step) begin
            if (chk) begin
                chk <= 1'b0;
            end else if (shift) begin
                idx <= idx - 1'b1;
            end else if (!full) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Entry storage: shift the worse neighbour down, or drop the new result into place.
    always_ff @(posedge clk) begin
        if (step && !clear && !reset) begin
            if (shift) begin
                entries[idx] <= entries[prev_idx];
            end else if (done) begin
                entries[idx] <= new_time;
            end
        end
    end

endmodule

// File: rtl/time_board_mux.sv
// Stopwatch display mux with two ranked leaderboards (up runs ascending,
// down runs descending). Accepts results over a valid/ready port and drives
// one registered display word selected by mode and rank.
module time_board_mux
    import time_board_pkg::*;
#(
    parameter int TIME_W = TIME_W_DEF,
    parameter int DEPTH  = 3,
    localparam int RANK_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [TIME_W-1:0]  live_time,
    time_board_mux_if.slave    rec,
    input  logic               clear,
    input  logic               sel_mode,
    input  logic [RANK_W-1:0]  sel_rank,
    output logic [TIME_W-1:0]  disp_time,
    output logic               disp_valid,
    output logic [RANK_W-1:0]  cnt_up,
    output logic [RANK_W-1:0]  cnt_dn
);

    state_t                       state;
    state_t                       state_nxt;
    logic                         mode_q;
    logic [TIME_W-1:0]            new_time;
    logic                         accept;
    logic                         step_up;
    logic                         step_dn;
    logic                         up_rej;
    logic                         dn_rej;
    logic                         up_done;
    logic                         dn_done;
    logic [DEPTH-1:0][TIME_W-1:0] up_entries;
    logic [DEPTH-1:0][TIME_W-1:0] dn_entries;
    logic [RANK_W-1:0]            sel_cnt;
    logic [TIME_W-1:0]            pick_time;
    logic                         pick_valid;
    logic                         hold;

    assign accept = rec.rec_valid && rec.rec_ready;

    rank_table #(.TIME_W(TIME_W), .DEPTH(DEPTH), .ASCEND(1'b1)) u_up (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .load     (accept && (rec.rec_mode == MODE_UP)),
        .step     (step_up),
        .new_time (new_time),
        .entries  (up_entries),
        .cnt      (cnt_up),
        .rej      (up_rej),
        .done     (up_done)
    );

    rank_table #(.TIME_W(TIME_W), .DEPTH(DEPTH), .ASCEND(1'b0)) u_dn (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .load     (accept && (rec.rec_mode == MODE_DOWN)),
        .step     (step_dn),
        .new_time (new_time),
        .entries  (dn_entries),
        .cnt      (cnt_dn),
        .rej      (dn_rej),
        .done     (dn_done)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: clear aborts an insert outright, without a drop pulse.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = INSERT;
            INSERT: begin
                if (clear)                  state_nxt = IDLE;
                else if (up_rej || dn_rej)  state_nxt = DROP;
                else if (up_done || dn_done) state_nxt = IDLE;
            end
            DROP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: handshake, drop pulse and per-table step enables.
    always_comb begin
        rec.rec_ready = (state == IDLE) && !clear;
        rec.rec_drop  = (state == DROP);
        step_up       = (state == INSERT) && (mode_q == MODE_UP);
        step_dn       = (state == INSERT) && (mode_q == MODE_DOWN);
    end

    // Latch the offered result at acceptance; it is held for the whole insert.
    always_ff @(posedge clk) begin
        if (accept) begin
            mode_q   <= rec.rec_mode;
            new_time <= rec.rec_time;
        end
    end

    // Display select: live time at rank 0, occupied entries by rank, else blank.
    always_comb begin
        sel_cnt    = (sel_mode == MODE_UP) ? cnt_up : cnt_dn;
        pick_time  = '0;
        pick_valid = 1'b0;
        if (sel_rank == '0) begin
            pick_time  = live_time;
            pick_valid = 1'b1;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if ((int'(sel_rank) == k + 1) && (k < int'(sel_cnt))) begin
                    pick_time  = (sel_mode == MODE_UP) ? up_entries[k] : dn_entries[k];
                    pick_valid = 1'b1;
                end
            end
        end
        hold = (state == INSERT) && (mode_q == sel_mode);
    end

    // Display register; frozen while the selected table is mid-insert.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_time  <= '0;
            disp_valid <= 1'b0;
        end else if (!hold) begin
            disp_time  <= pick_time;
            disp_valid <= pick_valid;
        end
    end

endmodule
